lcd_ctrl: RTL and testbench

LCD_CTRL -- requirements
Module: lcd_ctrl

---
 rtl/lcd_pkg.sv | 46 ++++
 rtl/lcd_nibble_tx.sv | 94 +++++++++
 rtl/lcd_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_lcd_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 4-bit write-only controller:
// FSM state encodings, default timing constants and the counter load helper.
package lcd_pkg;

    localparam int unsigned CNT_W = 20;

    // Default timings in cycles of a 27 MHz clock.
    localparam int unsigned T_PWR_DEF   = 405000;
    localparam int unsigned T_INIT1_DEF = 110700;
    localparam int unsigned T_INIT2_DEF = 2700;
    localparam int unsigned T_SETUP_DEF = 2;
    localparam int unsigned T_E_DEF     = 13;
    localparam int unsigned T_HOLD_DEF  = 2;
    localparam int unsigned T_GAP_DEF   = 27;
    localparam int unsigned T_CMD_DEF   = 1080;
    localparam int unsigned T_CLR_DEF   = 44280;

    typedef enum logic [3:0] {
        ST_PWR_WAIT,
        ST_INIT_NIB,
        ST_INIT_WAIT,
        ST_INIT_BYTES,
        ST_IDLE,
        ST_NIB_HI,
        ST_GAP,
        ST_NIB_LO,
        ST_EXEC_WAIT
    } lcd_state_e;

    typedef enum logic [1:0] {
        NT_IDLE,
        NT_SETUP,
        NT_PULSE,
        NT_HOLD
    } nib_phase_e;

    // A phase lasting t cycles loads t-1 and ends when the counter reads 0,
    // so t=0 still produces a single-cycle phase.
    function automatic logic [CNT_W-1:0] load_val(input int unsigned t);
        if (t == 0) begin
            return '0;
        end
        return CNT_W'(t - 1);
    endfunction

endpackage

// File: rtl/lcd_nibble_tx.sv
// Drives one 4-bit nibble onto the LCD bus: setup with E low, E pulse, hold.
// done_o is asserted on the last hold cycle so the caller can chain phases.
module lcd_nibble_tx
    import lcd_pkg::*;
#(
    parameter int unsigned T_SETUP = T_SETUP_DEF,
    parameter int unsigned T_E     = T_E_DEF,
    parameter int unsigned T_HOLD  = T_HOLD_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       rs_i,
    input  logic [3:0] db_i,
    output logic       done_o,
    output logic       e_o,
    output logic       rs_o,
    output logic [3:0] db_o
);

    nib_phase_e       phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             e_q, e_d;
    logic             rs_q, rs_d;
    logic [3:0]       db_q, db_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= NT_IDLE;
            cnt_q   <= '0;
            e_q     <= 1'b0;
            rs_q    <= 1'b0;
            db_q    <= 4'h0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            e_q     <= e_d;
            rs_q    <= rs_d;
            db_q    <= db_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        e_d     = e_q;
        rs_d    = rs_q;
        db_d    = db_q;
        done_o  = 1'b0;
        case (phase_q)
            NT_IDLE: begin
                // RS/DB keep their last value while idle.
                if (start_i) begin
                    rs_d    = rs_i;
                    db_d    = db_i;
                    cnt_d   = load_val(T_SETUP);
                    phase_d = NT_SETUP;
                end
            end
            NT_SETUP: begin
                if (cnt_q == '0) begin
                    e_d     = 1'b1;
                    cnt_d   = load_val(T_E);
                    phase_d = NT_PULSE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            NT_PULSE: begin
                if (cnt_q == '0) begin
                    e_d     = 1'b0;
                    cnt_d   = load_val(T_HOLD);
                    phase_d = NT_HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            NT_HOLD: begin
                if (cnt_q == '0) begin
                    done_o  = 1'b1;
                    phase_d = NT_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: phase_d = NT_IDLE;
        endcase
    end

    assign e_o  = e_q;
    assign rs_o = rs_q;
    assign db_o = db_q;

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 4-bit write-only controller: runs the power-on init sequence, then
// writes one requested byte at a time as two nibbles plus an execution wait.
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int unsigned T_PWR   = T_PWR_DEF,
    parameter int unsigned T_INIT1 = T_INIT1_DEF,
    parameter int unsigned T_INIT2 = T_INIT2_DEF,
    parameter int unsigned T_SETUP = T_SETUP_DEF,
    parameter int unsigned T_E     = T_E_DEF,
    parameter int unsigned T_HOLD  = T_HOLD_DEF,
    parameter int unsigned T_GAP   = T_GAP_DEF,
    parameter int unsigned T_CMD   = T_CMD_DEF,
    parameter int unsigned T_CLR   = T_CLR_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       req_ready,
    output logic       init_done,
    output logic       lcd_e,
    output logic       lcd_rw,
    output logic       lcd_rs,
    output logic [3:0] lcd_db
);

    lcd_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             armed_q, armed_d;
    logic [1:0]       nib_idx_q, nib_idx_d;
    logic [2:0]       byte_idx_q, byte_idx_d;
    logic             rs_q, rs_d;
    logic [7:0]       data_q, data_d;
    logic             init_done_q, init_done_d;

    logic             nib_start;
    logic             nib_rs;
    logic [3:0]       nib_db;
    logic             nib_done;
    logic [7:0]       rom_byte;
    logic             is_clr;

    function automatic logic [3:0] init_nib(input logic [1:0] i);
        return (i == 2'd3) ? 4'h2 : 4'h3;
    endfunction

    function automatic logic [CNT_W-1:0] init_wait(input logic [1:0] i);
        case (i)
            2'd0:    return load_val(T_INIT1);
            2'd1:    return load_val(T_INIT2);
            default: return load_val(T_CMD);
        endcase
    endfunction

    // Function set 4-bit/2 lines, display on, clear, entry mode increment.
    function automatic logic [7:0] init_byte(input logic [1:0] i);
        case (i)
            2'd0:    return 8'h28;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    lcd_nibble_tx #(
        .T_SETUP (T_SETUP),
        .T_E     (T_E),
        .T_HOLD  (T_HOLD)
    ) u_nib (
        .clk     (clk),
        .rst     (rst),
        .start_i (nib_start),
        .rs_i    (nib_rs),
        .db_i    (nib_db),
        .done_o  (nib_done),
        .e_o     (lcd_e),
        .rs_o    (lcd_rs),
        .db_o    (lcd_db)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_PWR_WAIT;
            cnt_q       <= '0;
            armed_q     <= 1'b0;
            nib_idx_q   <= 2'd0;
            byte_idx_q  <= 3'd0;
            rs_q        <= 1'b0;
            data_q      <= 8'h00;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            armed_q     <= armed_d;
            nib_idx_q   <= nib_idx_d;
            byte_idx_q  <= byte_idx_d;
            rs_q        <= rs_d;
            data_q      <= data_d;
            init_done_q <= init_done_d;
        end
    end

    assign rom_byte  = init_byte(byte_idx_q[1:0]);
    // Clear display (0x01) and return home (0x02/0x03) need the long wait.
    assign is_clr    = !rs_q && (data_q[7:2] == 6'd0);
    assign req_ready = (state_q == ST_IDLE) && init_done_q;
    assign init_done = init_done_q;
    assign lcd_rw    = 1'b0;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        armed_d     = armed_q;
        nib_idx_d   = nib_idx_q;
        byte_idx_d  = byte_idx_q;
        rs_d        = rs_q;
        data_d      = data_q;
        init_done_d = init_done_q;
        nib_start   = 1'b0;
        nib_rs      = 1'b0;
        nib_db      = 4'h0;
        case (state_q)
            ST_PWR_WAIT: begin
                // The counter resets to 0, so the first cycle arms it.
                if ((!armed_q && T_PWR <= 1) || (armed_q && cnt_q == '0)) begin
                    nib_start = 1'b1;
                    nib_db    = init_nib(2'd0);
                    nib_idx_d = 2'd0;
                    state_d   = ST_INIT_NIB;
                end else if (!armed_q) begin
                    armed_d = 1'b1;
                    cnt_d   = load_val(T_PWR - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_INIT_NIB: begin
                if (nib_done) begin
                    cnt_d   = init_wait(nib_idx_q);
                    state_d = ST_INIT_WAIT;
                end
            end
            ST_INIT_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (nib_idx_q == 2'd3) begin
                    byte_idx_d = 3'd0;
                    state_d    = ST_INIT_BYTES;
                end else begin
                    nib_idx_d = nib_idx_q + 2'd1;
                    nib_start = 1'b1;
                    nib_db    = init_nib(nib_idx_q + 2'd1);
                    state_d   = ST_INIT_NIB;
                end
            end
            ST_INIT_BYTES: begin
                if (byte_idx_q == 3'd4) begin
                    init_done_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    rs_d       = 1'b0;
                    data_d     = rom_byte;
                    nib_start  = 1'b1;
                    nib_db     = rom_byte[7:4];
                    byte_idx_d = byte_idx_q + 3'd1;
                    state_d    = ST_NIB_HI;
                end
            end
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    rs_d      = req_rs;
                    data_d    = req_data;
                    nib_start = 1'b1;
                    nib_rs    = req_rs;
                    nib_db    = req_data[7:4];
                    state_d   = ST_NIB_HI;
                end
            end
            ST_NIB_HI: begin
                if (nib_done) begin
                    cnt_d   = load_val(T_GAP);
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    nib_start = 1'b1;
                    nib_rs    = rs_q;
                    nib_db    = data_q[3:0];
                    state_d   = ST_NIB_LO;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_NIB_LO: begin
                if (nib_done) begin
                    cnt_d   = is_clr ? load_val(T_CLR) : load_val(T_CMD);
                    state_d = ST_EXEC_WAIT;
                end
            end
            ST_EXEC_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = init_done_q ? ST_IDLE : ST_INIT_BYTES;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_PWR_WAIT;
        endcase
    end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl with shortened init timings; the bus monitor
// records every E pulse so nibble order, RS and pulse width can be checked.
module tb_lcd_ctrl;

    localparam int unsigned P_PWR   = 50;
    localparam int unsigned P_INIT1 = 20;
    localparam int unsigned P_INIT2 = 10;
    localparam int unsigned P_CLR   = 3000;
    localparam int          LIM     = 20000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_rs = 1'b0;
    logic [7:0] req_data = 8'h00;
    logic       req_ready, init_done, lcd_e, lcd_rw, lcd_rs;
    logic [3:0] lcd_db;

    int total = 0;
    int bad   = 0;

    logic [4:0] pulse_q[$];
    int         width_q[$];
    int         done_rises;
    int         hi_cnt;
    logic       e_prev, done_prev;

    logic [3:0] exp_init [12] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8,
                                  4'h0, 4'hC, 4'h0, 4'h1, 4'h0, 4'h6};

    lcd_ctrl #(
        .T_PWR   (P_PWR),
        .T_INIT1 (P_INIT1),
        .T_INIT2 (P_INIT2),
        .T_SETUP (2),
        .T_E     (13),
        .T_HOLD  (2),
        .T_GAP   (27),
        .T_CMD   (1080),
        .T_CLR   (P_CLR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_rs    (req_rs),
        .req_data  (req_data),
        .req_ready (req_ready),
        .init_done (init_done),
        .lcd_e     (lcd_e),
        .lcd_rw    (lcd_rw),
        .lcd_rs    (lcd_rs),
        .lcd_db    (lcd_db)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst) begin
            pulse_q.delete();
            width_q.delete();
            done_rises <= 0;
            hi_cnt     <= 0;
            e_prev     <= 1'b0;
            done_prev  <= 1'b0;
        end else begin
            if (lcd_e && !e_prev) begin
                pulse_q.push_back({lcd_rs, lcd_db});
                hi_cnt <= 1;
            end else if (lcd_e) begin
                hi_cnt <= hi_cnt + 1;
            end
            if (!lcd_e && e_prev) width_q.push_back(hi_cnt);
            if (init_done && !done_prev) done_rises <= done_rises + 1;
            e_prev    <= lcd_e;
            done_prev <= init_done;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic wait_init(input string tag, input bit poke);
        int n = 0;
        int early_rdy = 0;
        int bad_w = 0;
        if (poke) begin
            req_valid = 1'b1;
            req_rs    = 1'b1;
            req_data  = 8'hFF;
        end
        while (init_done !== 1'b1 && n < LIM) begin
            if (req_ready !== 1'b0) early_rdy++;
            if (n == 300) req_valid = 1'b0;
            @(negedge clk);
            n++;
        end
        req_valid = 1'b0;
        chk({tag, "_done"}, {31'd0, init_done}, 32'd1);
        chk({tag, "_rdy_early"}, early_rdy, 0);
        @(negedge clk);
        #1;
        chk({tag, "_npulse"}, pulse_q.size(), 12);
        for (int i = 0; i < 12; i++) begin
            if (i < pulse_q.size())
                chk($sformatf("%s_nib%0d", tag, i), {27'd0, pulse_q[i]}, {28'd0, exp_init[i]});
        end
        foreach (width_q[i]) if (width_q[i] != 13) bad_w++;
        chk({tag, "_ewidth"}, bad_w, 0);
        chk({tag, "_rises"}, done_rises, 1);
        chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (req_ready !== 1'b1 && n < LIM) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Pulse i of the write is exp[5*i +: 5] = {rs, db}.
    task automatic chk_pulses(input string tag, input int base, input int n, input logic [19:0] exp);
        chk({tag, "_npulse"}, pulse_q.size() - base, n);
        for (int i = 0; i < n; i++) begin
            if (base + i < pulse_q.size())
                chk($sformatf("%s_p%0d", tag, i), {27'd0, pulse_q[base + i]}, {27'd0, exp[5*i +: 5]});
        end
    endtask

    task automatic send(input string tag, input logic rs, input logic [7:0] d,
                        input int exp_n, input logic [19:0] exp_p);
        int base;
        int n;
        base = pulse_q.size();
        chk({tag, "_rdy"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_rs    = rs;
        req_data  = d;
        @(negedge clk);
        req_valid = 1'b0;
        count_busy(n);
        chk({tag, "_busy"}, n, exp_n);
        chk_pulses(tag, base, 2, exp_p);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_e", {31'd0, lcd_e}, 32'd0);
        chk("rst_rw", {31'd0, lcd_rw}, 32'd0);
        chk("rst_rs", {31'd0, lcd_rs}, 32'd0);
        chk("rst_db", {28'd0, lcd_db}, 32'd0);
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_done", {31'd0, init_done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Requests offered during init must be ignored.
        wait_init("init1", 1'b1);

        // 0x41 data: 2*(2+13+2)+27+1080 = 1141 busy cycles.
        send("wr41", 1'b1, 8'h41, 1141, {5'h00, 5'h00, 5'h11, 5'h14});
        chk("idle_e", {31'd0, lcd_e}, 32'd0);
        chk("idle_rs", {31'd0, lcd_rs}, 32'd1);
        chk("idle_db", {28'd0, lcd_db}, 32'h1);
        chk("rw", {31'd0, lcd_rw}, 32'd0);

        // Clear display: 34+27+3000 = 3061 busy cycles.
        send("clr", 1'b0, 8'h01, 3061, {5'h00, 5'h00, 5'h01, 5'h00});

        // 0x80 then a held request whose data changes to 0xAA just before ready.
        base = pulse_q.size();
        req_valid = 1'b1;
        req_rs    = 1'b0;
        req_data  = 8'h80;
        @(negedge clk);
        req_rs   = 1'b1;
        req_data = 8'h55;
        n = 0;
        while (req_ready !== 1'b1 && n < LIM) begin
            n++;
            if (n == 1141) req_data = 8'hAA;
            @(negedge clk);
        end
        chk("cmd80_busy", n, 1141);
        @(negedge clk);
        req_valid = 1'b0;
        count_busy(n);
        chk("wrAA_busy", n, 1141);
        chk_pulses("held", base, 4, {5'h1A, 5'h1A, 5'h00, 5'h08});

        // Reset in the middle of an E pulse.
        req_valid = 1'b1;
        req_rs    = 1'b1;
        req_data  = 8'h33;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (lcd_e !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("e_seen", {31'd0, lcd_e}, 32'd1);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_e", {31'd0, lcd_e}, 32'd0);
        chk("arst_done", {31'd0, init_done}, 32'd0);
        chk("arst_ready", {31'd0, req_ready}, 32'd0);
        chk("arst_db", {28'd0, lcd_db}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_init("init2", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
